usb_link_state_ctrl: RTL and testbench

Device-side USB 2.0 link-state controller that drives the UTMI control inputs of `usb_phy_wrapper`. It detects bus reset and runs the high-speed chirp handshake (device Chirp K, host K-J detection). It also handles suspend/resume and the HS-to-FS reversion needed to tell reset from suspend. It sits in the 60 MHz `clk` domain between the protocol engine and the PHY wrapper, and owns the UTMI TX port only while chirping.

---
 rtl/usb_link_pkg.sv | 57 +++++
 rtl/usb_link_state_ctrl_if.sv | 27 ++
 rtl/usb_link_state_ctrl_chirp_detector.sv | 69 ++++++
 rtl/usb_link_state_ctrl.sv | 158 +++++++++++++++
 tb/tb_usb_link_state_ctrl.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/usb_link_pkg.sv
// Shared types and encodings for the USB device link-state controller.
package usb_link_pkg;

  typedef enum logic [2:0] {
    ST_DETACHED   = 3'd0,
    ST_FS_IDLE    = 3'd1,
    ST_CHIRP_K    = 3'd2,
    ST_CHIRP_WAIT = 3'd3,
    ST_HS_IDLE    = 3'd4,
    ST_HS_REVERT  = 3'd5,
    ST_SUSPEND    = 3'd6
  } link_state_t;

  localparam logic [1:0] OPMODE_NORMAL  = 2'b00;
  localparam logic [1:0] OPMODE_NODRIVE = 2'b01;
  localparam logic [1:0] OPMODE_RAW     = 2'b10;

  localparam logic [1:0] XCVR_HS = 2'b00;
  localparam logic [1:0] XCVR_FS = 2'b01;

  localparam logic [1:0] LS_SE0 = 2'b00;
  localparam logic [1:0] LS_J   = 2'b01;
  localparam logic [1:0] LS_K   = 2'b10;
  localparam logic [1:0] LS_SE1 = 2'b11;

  localparam logic [1:0] SPEED_HS = 2'b00;
  localparam logic [1:0] SPEED_FS = 2'b01;

  // K-J pairs x3 complete the host chirp sequence
  localparam logic [2:0] CHIRP_DONE = 3'd6;

  typedef struct packed {
    logic [1:0] xcvr_select;
    logic       termselect;
    logic [1:0] op_mode;
    logic       tx_valid;
  } utmi_ctrl_t;

  // UTMI control pattern owned by each link state
  function automatic utmi_ctrl_t state_ctrl(input link_state_t s);
    utmi_ctrl_t c;
    c = '{xcvr_select: XCVR_FS, termselect: 1'b0, op_mode: OPMODE_NODRIVE, tx_valid: 1'b0};
    case (s)
      ST_FS_IDLE, ST_SUSPEND, ST_HS_REVERT:
        c = '{xcvr_select: XCVR_FS, termselect: 1'b1, op_mode: OPMODE_NORMAL, tx_valid: 1'b0};
      ST_CHIRP_K:
        c = '{xcvr_select: XCVR_HS, termselect: 1'b1, op_mode: OPMODE_RAW, tx_valid: 1'b1};
      ST_CHIRP_WAIT:
        c = '{xcvr_select: XCVR_HS, termselect: 1'b1, op_mode: OPMODE_NORMAL, tx_valid: 1'b0};
      ST_HS_IDLE:
        c = '{xcvr_select: XCVR_HS, termselect: 1'b0, op_mode: OPMODE_NORMAL, tx_valid: 1'b0};
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/usb_link_state_ctrl_if.sv
// Link-controller bundle: protocol-engine controls, UTMI control/TX and status.
interface usb_link_state_ctrl_if;
  logic       connect_en;
  logic       hs_en;
  logic [1:0] utmi_line_state;
  logic       utmi_tx_ready;
  logic [1:0] utmi_xcvr_select;
  logic       utmi_termselect;
  logic [1:0] utmi_op_mode;
  logic       utmi_tx_valid;
  logic [7:0] utmi_tx_data;
  logic       bus_reset;
  logic [1:0] link_speed;
  logic       suspended;

  modport master (
    input  connect_en, hs_en, utmi_line_state, utmi_tx_ready,
    output utmi_xcvr_select, utmi_termselect, utmi_op_mode, utmi_tx_valid,
           utmi_tx_data, bus_reset, link_speed, suspended
  );

  modport slave (
    output connect_en, hs_en, utmi_line_state, utmi_tx_ready,
    input  utmi_xcvr_select, utmi_termselect, utmi_op_mode, utmi_tx_valid,
           utmi_tx_data, bus_reset, link_speed, suspended
  );
endinterface

// File: rtl/usb_link_state_ctrl_chirp_detector.sv
// Counts alternating host K/J chirps, each filtered for T_FILT stable cycles.
module usb_chirp_detector
  import usb_link_pkg::*;
#(
  parameter int unsigned T_FILT = 150
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic [1:0] line_state,
  output logic [2:0] chirp_cnt
);

  localparam int unsigned FW = (T_FILT > 1) ? $clog2(T_FILT + 1) : 1;
  localparam logic [FW-1:0] FILT_LAST = FW'(T_FILT - 1);

  logic [1:0]    prev_q;
  logic [FW-1:0] run_q;
  logic [FW-1:0] run_now;
  logic [2:0]    cnt_q;
  logic [2:0]    cnt_d;
  logic          qual;

  // Saturating run length of the current line state, this sample included
  always_comb begin
    run_now = '0;
    if (line_state == prev_q) begin
      run_now = (run_q == '1) ? run_q : run_q + FW'(1);
    end
    qual = (run_now == FILT_LAST);
  end

  // K advances from even counts, J from odd; repeated K or long SE0 restarts
  always_comb begin
    cnt_d = cnt_q;
    if (qual) begin
      case (line_state)
        LS_K: begin
          if (cnt_q == CHIRP_DONE) cnt_d = cnt_q;
          else if (cnt_q[0])       cnt_d = 3'd0;
          else                     cnt_d = cnt_q + 3'd1;
        end
        LS_J:    if (cnt_q[0]) cnt_d = cnt_q + 3'd1;
        LS_SE0:  cnt_d = 3'd0;
        default: ;
      endcase
    end
  end

  // Filter and count registers; clear restarts everything from the next sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= LS_SE1;
      run_q  <= '0;
      cnt_q  <= 3'd0;
    end else if (clear) begin
      prev_q <= line_state;
      run_q  <= '0;
      cnt_q  <= 3'd0;
    end else begin
      prev_q <= line_state;
      run_q  <= run_now;
      cnt_q  <= cnt_d;
    end
  end

  assign chirp_cnt = cnt_q;

endmodule

// File: rtl/usb_link_state_ctrl.sv
// Device-side USB 2.0 link-state controller: reset detect, HS chirp, suspend/resume.
module usb_link_state_ctrl
  import usb_link_pkg::*;
#(
  parameter int unsigned T_RST    = 150,
  parameter int unsigned T_SUSP   = 180000,
  parameter int unsigned T_CHIRP  = 120000,
  parameter int unsigned T_FILT   = 150,
  parameter int unsigned T_WAIT   = 150000,
  parameter int unsigned T_REVERT = 6000,
  parameter int unsigned CW       = $clog2(T_SUSP + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  usb_link_state_ctrl_if.master bus
);

  localparam logic [CW-1:0] RST_LAST    = CW'(T_RST - 1);
  localparam logic [CW-1:0] SUSP_LAST   = CW'(T_SUSP - 1);
  localparam logic [CW-1:0] CHIRP_LAST  = CW'(T_CHIRP - 1);
  localparam logic [CW-1:0] FILT_LAST   = CW'(T_FILT - 1);
  localparam logic [CW-1:0] WAIT_LAST   = CW'(T_WAIT - 1);
  localparam logic [CW-1:0] REVERT_LAST = CW'(T_REVERT - 1);

  link_state_t   state_q, state_d;
  logic [CW-1:0] timer_q, timer_d;
  logic [CW-1:0] run_q, run_now;
  logic [1:0]    prev_ls_q;
  logic [1:0]    ls;
  logic          was_hs_q, was_hs_d;
  logic          bus_reset_q, bus_reset_d;
  logic [1:0]    speed_q, speed_d;
  logic          susp_q;
  utmi_ctrl_t    ctrl_q;
  logic [2:0]    chirp_cnt;
  logic          chirp_clear;

  assign ls          = bus.utmi_line_state;
  assign chirp_clear = (state_q != ST_CHIRP_WAIT);

  usb_chirp_detector #(.T_FILT(T_FILT)) u_chirp (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (chirp_clear),
    .line_state (ls),
    .chirp_cnt  (chirp_cnt)
  );

  // Saturating run length of the current line state, this sample included
  always_comb begin
    run_now = '0;
    if (ls == prev_ls_q) begin
      run_now = (run_q == '1) ? run_q : run_q + CW'(1);
    end
  end

  // Next-state, bus-reset pulse, HS memory, shared timer and speed decode
  always_comb begin
    state_d     = state_q;
    bus_reset_d = 1'b0;
    was_hs_d    = was_hs_q;
    timer_d     = '0;
    speed_d     = SPEED_FS;

    case (state_q)
      ST_DETACHED: if (bus.connect_en) state_d = ST_FS_IDLE;
      ST_FS_IDLE: begin
        if (ls == LS_SE0 && run_now == RST_LAST) begin
          bus_reset_d = 1'b1;
          state_d     = bus.hs_en ? ST_CHIRP_K : ST_FS_IDLE;
        end else if (ls == LS_J && run_now == SUSP_LAST) begin
          state_d = ST_SUSPEND;
        end
      end
      ST_CHIRP_K: if (timer_q == CHIRP_LAST) state_d = ST_CHIRP_WAIT;
      ST_CHIRP_WAIT: begin
        if (chirp_cnt == CHIRP_DONE)  state_d = ST_HS_IDLE;
        else if (timer_q == WAIT_LAST) state_d = ST_FS_IDLE;
      end
      ST_HS_IDLE: if (ls == LS_SE0 && run_now == SUSP_LAST) state_d = ST_HS_REVERT;
      ST_HS_REVERT: begin
        if (timer_q == REVERT_LAST) begin
          case (ls)
            LS_SE0: begin
              bus_reset_d = 1'b1;
              state_d     = ST_CHIRP_K;
            end
            LS_J:    state_d = ST_SUSPEND;
            default: state_d = ST_HS_IDLE;
          endcase
        end
      end
      ST_SUSPEND: begin
        if (ls == LS_K && run_now == FILT_LAST) begin
          state_d = was_hs_q ? ST_HS_IDLE : ST_FS_IDLE;
        end else if (ls == LS_SE0 && run_now == RST_LAST) begin
          bus_reset_d = 1'b1;
          was_hs_d    = 1'b0;
          state_d     = bus.hs_en ? ST_CHIRP_K : ST_FS_IDLE;
        end
      end
      default: state_d = ST_DETACHED;
    endcase

    // Detach overrides any coincident qualification, including its reset pulse
    if (!bus.connect_en) begin
      state_d     = ST_DETACHED;
      bus_reset_d = 1'b0;
    end

    if (state_d == ST_HS_IDLE) was_hs_d = 1'b1;
    if (state_d == ST_FS_IDLE || state_d == ST_DETACHED) was_hs_d = 1'b0;

    if (state_d == state_q) begin
      timer_d = (timer_q == '1) ? timer_q : timer_q + CW'(1);
    end

    if (state_d == ST_HS_IDLE ||
        ((state_d == ST_HS_REVERT || state_d == ST_SUSPEND) && was_hs_d)) begin
      speed_d = SPEED_HS;
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_DETACHED;
      timer_q     <= '0;
      run_q       <= '0;
      prev_ls_q   <= LS_SE1;
      was_hs_q    <= 1'b0;
      ctrl_q      <= state_ctrl(ST_DETACHED);
      bus_reset_q <= 1'b0;
      speed_q     <= SPEED_FS;
      susp_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      run_q       <= run_now;
      prev_ls_q   <= ls;
      was_hs_q    <= was_hs_d;
      ctrl_q      <= state_ctrl(state_d);
      bus_reset_q <= bus_reset_d;
      speed_q     <= speed_d;
      susp_q      <= (state_d == ST_SUSPEND);
    end
  end

  assign bus.utmi_xcvr_select = ctrl_q.xcvr_select;
  assign bus.utmi_termselect  = ctrl_q.termselect;
  assign bus.utmi_op_mode     = ctrl_q.op_mode;
  assign bus.utmi_tx_valid    = ctrl_q.tx_valid;
  assign bus.utmi_tx_data     = 8'h00;
  assign bus.bus_reset        = bus_reset_q;
  assign bus.link_speed       = speed_q;
  assign bus.suspended        = susp_q;

endmodule

// File: tb/tb_usb_link_state_ctrl.sv
// Directed bench for usb_link_state_ctrl with a per-cycle expectation queue.
module tb_usb_link_state_ctrl;
  import usb_link_pkg::*;

  typedef struct packed {
    logic [1:0] xcvr;
    logic       term;
    logic [1:0] op;
    logic       txv;
    logic [7:0] data;
    logic       br;
    logic [1:0] spd;
    logic       susp;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;
  obs_t exp_q[$];
  string tag_q[$];

  obs_t e_det, e_fs, e_fs_br, e_ck, e_ck_br, e_cw, e_hs, e_rev, e_susp, e_susp_fs;

  always #5 clk = ~clk;

  usb_link_state_ctrl_if bus ();

  usb_link_state_ctrl #(
    .T_RST(4), .T_SUSP(20), .T_CHIRP(10), .T_FILT(3), .T_WAIT(30), .T_REVERT(5)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  function automatic obs_t mk(input logic [1:0] x, input logic t, input logic [1:0] o,
                              input logic v, input logic b, input logic [1:0] s,
                              input logic su);
    obs_t r;
    r = {x, t, o, v, 8'h00, b, s, su};
    return r;
  endfunction

  task automatic compare();
    obs_t o, e;
    string t;
    o = {bus.utmi_xcvr_select, bus.utmi_termselect, bus.utmi_op_mode, bus.utmi_tx_valid,
         bus.utmi_tx_data, bus.bus_reset, bus.link_speed, bus.suspended};
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%05h expected=%05h", t, o, e);
    end
  endtask

  // Drive one line-state sample, queue the expected outputs after the edge, check
  task automatic step(input logic [1:0] ls, input obs_t e, input string tag);
    bus.utmi_line_state = ls;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic steps(input int n, input logic [1:0] ls, input obs_t e, input string tag);
    for (int i = 0; i < n; i++) step(ls, e, tag);
  endtask

  initial begin
    e_det     = mk(2'b01, 1'b0, 2'b01, 1'b0, 1'b0, 2'b01, 1'b0);
    e_fs      = mk(2'b01, 1'b1, 2'b00, 1'b0, 1'b0, 2'b01, 1'b0);
    e_fs_br   = mk(2'b01, 1'b1, 2'b00, 1'b0, 1'b1, 2'b01, 1'b0);
    e_ck      = mk(2'b00, 1'b1, 2'b10, 1'b1, 1'b0, 2'b01, 1'b0);
    e_ck_br   = mk(2'b00, 1'b1, 2'b10, 1'b1, 1'b1, 2'b01, 1'b0);
    e_cw      = mk(2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 2'b01, 1'b0);
    e_hs      = mk(2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0);
    e_rev     = mk(2'b01, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0);
    e_susp    = mk(2'b01, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 1'b1);
    e_susp_fs = mk(2'b01, 1'b1, 2'b00, 1'b0, 1'b0, 2'b01, 1'b1);

    rst_n               = 1'b0;
    bus.connect_en      = 1'b1;
    bus.hs_en           = 1'b1;
    bus.utmi_tx_ready   = 1'b0;
    bus.utmi_line_state = LS_J;

    // Reset holds DETACHED outputs; attach one cycle after release
    steps(2, LS_J, e_det, "reset_hold");
    rst_n = 1'b1;
    step(LS_J, e_fs, "attach");

    // SE0 one cycle short of a reset is ignored
    steps(3, LS_SE0, e_fs, "short_se0");
    step(LS_J, e_fs, "short_se0_end");

    // Full SE0 reset, then 10-cycle device Chirp K
    steps(3, LS_SE0, e_fs, "se0_run");
    step(LS_SE0, e_ck_br, "bus_reset");
    steps(9, LS_SE0, e_ck, "chirp_k");
    step(LS_SE0, e_cw, "chirp_wait_entry");

    // Host K-J x3 of 3 cycles each reaches HS
    for (int i = 0; i < 3; i++) begin
      steps(3, LS_K, e_cw, "host_k");
      steps(3, LS_J, e_cw, "host_j");
    end
    step(LS_SE0, e_hs, "hs_idle");

    // HS idle SE0 for 20 cycles -> reversion, J afterwards -> suspend
    steps(18, LS_SE0, e_hs, "hs_se0");
    step(LS_SE0, e_rev, "hs_revert");
    steps(4, LS_J, e_rev, "revert_settle");
    step(LS_J, e_susp, "suspend_hs");

    // K of 3 cycles resumes to HS
    steps(2, LS_K, e_susp, "resume_k");
    step(LS_K, e_hs, "resume_hs");
    step(LS_J, e_hs, "hs_j_idle");

    // Reversion that still sees SE0 is a reset and re-chirps
    steps(19, LS_SE0, e_hs, "hs_se0_2");
    step(LS_SE0, e_rev, "hs_revert_2");
    steps(4, LS_SE0, e_rev, "revert_settle_2");
    step(LS_SE0, e_ck_br, "hs_bus_reset");
    steps(9, LS_SE0, e_ck, "chirp_k_2");
    step(LS_SE0, e_cw, "chirp_wait_entry_2");

    // Silent host: fall back to FS after 30 cycles
    steps(29, LS_J, e_cw, "host_silent");
    step(LS_J, e_fs, "chirp_timeout");

    // Detach in the middle of Chirp K
    steps(3, LS_SE0, e_fs, "se0_run_2");
    step(LS_SE0, e_ck_br, "bus_reset_2");
    steps(3, LS_SE0, e_ck, "chirp_k_3");
    bus.connect_en = 1'b0;
    step(LS_SE0, e_det, "detach_mid_chirp");
    step(LS_SE0, e_det, "detached_hold");
    bus.connect_en = 1'b1;
    step(LS_J, e_fs, "reattach");

    // FS-only reset pulses but stays in FS_IDLE
    bus.hs_en = 1'b0;
    steps(3, LS_SE0, e_fs, "fs_only_se0");
    step(LS_SE0, e_fs_br, "fs_only_reset");
    step(LS_SE0, e_fs, "fs_only_after");

    // Detach coinciding with reset qualification: no pulse
    step(LS_J, e_fs, "idle_j");
    steps(3, LS_SE0, e_fs, "se0_run_3");
    bus.connect_en = 1'b0;
    step(LS_SE0, e_det, "detach_wins");

    // FS suspend after 20 J cycles, resume back to FS
    bus.connect_en = 1'b1;
    steps(19, LS_J, e_fs, "fs_j_idle");
    step(LS_J, e_susp_fs, "fs_suspend");
    steps(2, LS_K, e_susp_fs, "fs_resume_k");
    step(LS_K, e_fs, "fs_resume");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
